// File: rtl/mapper_mem_sequencer_if.sv
// Bus bundle between the slot mapper / CPU side, the memory controller and
// mapper_mem_sequencer. The sequencer uses the slave view and the CPU/memory
// environment uses the master view.
interface mapper_mem_sequencer_if #(
  parameter int ADDR_W = 27
);
  // CPU / mapper side
  logic              cpu_req;
  logic              ram_cs;
  logic [ADDR_W-1:0] ram_addr;
  logic              cpu_rd;
  logic              flush;
  logic              cpu_wait;
  logic [7:0]        cpu_data;
  logic              data_valid;
  logic              timeout_err;
  // memory controller side
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport slave (
    input  cpu_req, ram_cs, ram_addr, cpu_rd, flush, mem_ack, mem_data,
    output mem_req, mem_addr, cpu_wait, cpu_data, data_valid, timeout_err
  );

  modport master (
    output cpu_req, ram_cs, ram_addr, cpu_rd, flush, mem_ack, mem_data,
    input  mem_req, mem_addr, cpu_wait, cpu_data, data_valid, timeout_err
  );
endinterface

// File: rtl/mapper_mem_sequencer.sv
// mapper_mem_sequencer: turns each mapped CPU read into one registered request
// to the shared memory controller, stalls the CPU until data returns, and
// holds the returned byte stable for the slot data mux. A request that is not
// acknowledged within TIMEOUT cycles returns OPEN_BUS and sets a sticky error.
// Optional one-entry last-read cache: define MAPPER_SEQ_LASTHIT_EN.
module mapper_mem_sequencer #(
  parameter int          ADDR_W   = 27,
  parameter int          TIMEOUT  = 64,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  mapper_mem_sequencer_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // last counter value before the request is abandoned
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic              data_valid_q, data_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              start;
  logic              hit;

`ifdef MAPPER_SEQ_LASTHIT_EN
  logic              lh_vld_q, lh_vld_d;
  logic [ADDR_W-1:0] lh_tag_q, lh_tag_d;
  logic [7:0]        lh_byte_q, lh_byte_d;

  // a flush in the start cycle forces a miss
  assign hit = start && lh_vld_q && (lh_tag_q == bus.ram_addr) && !bus.flush;
`else
  logic unused_flush;

  assign unused_flush = bus.flush;
  assign hit          = 1'b0;
`endif

  assign start = (state_q == S_IDLE) && bus.cpu_req && bus.ram_cs && bus.cpu_rd;

  // the CPU must be stalled in the start cycle itself, hence the combinational term
  assign bus.cpu_wait    = !reset && (start || (state_q == S_REQ));
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.cpu_data    = cpu_data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.timeout_err = timeout_err_q;

  // next-state logic for the access sequencer and the last-hit entry
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    cpu_data_d    = cpu_data_q;
    data_valid_d  = data_valid_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
`ifdef MAPPER_SEQ_LASTHIT_EN
    lh_vld_d      = lh_vld_q;
    lh_tag_d      = lh_tag_q;
    lh_byte_d     = lh_byte_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (hit) begin
            cpu_data_d   = cpu_data_q;
`ifdef MAPPER_SEQ_LASTHIT_EN
            cpu_data_d   = lh_byte_q;
`endif
            data_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            mem_addr_d   = bus.ram_addr;
            mem_req_d    = 1'b1;
            data_valid_d = 1'b0;
            cnt_d        = 8'd0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        // an ack in the expiry cycle still wins over the timeout
        if (bus.mem_ack) begin
          cpu_data_d   = bus.mem_data;
          data_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = S_HOLD;
`ifdef MAPPER_SEQ_LASTHIT_EN
          lh_vld_d     = 1'b1;
          lh_tag_d     = mem_addr_q;
          lh_byte_d    = bus.mem_data;
`endif
        end else if (cnt_q == CNT_LAST) begin
          cpu_data_d    = OPEN_BUS;
          data_valid_d  = 1'b1;
          timeout_err_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (!bus.cpu_rd) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

`ifdef MAPPER_SEQ_LASTHIT_EN
    if (bus.flush) begin
      lh_vld_d = 1'b0;
    end
`endif
  end

  // state registers; reset clears everything immediately, dropping mem_req mid-request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      cpu_data_q    <= OPEN_BUS;
      data_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 8'd0;
`ifdef MAPPER_SEQ_LASTHIT_EN
      lh_vld_q      <= 1'b0;
      lh_tag_q      <= '0;
      lh_byte_q     <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      cpu_data_q    <= cpu_data_d;
      data_valid_q  <= data_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
`ifdef MAPPER_SEQ_LASTHIT_EN
      lh_vld_q      <= lh_vld_d;
      lh_tag_q      <= lh_tag_d;
      lh_byte_q     <= lh_byte_d;
`endif
    end
  end

endmodule

// File: tb/tb_mapper_mem_sequencer.sv
// Scoreboard bench for mapper_mem_sequencer: a CPU driver issues reads and
// pushes expected results, a memory responder answers with planned delays,
// and a monitor checks every completed access.
module tb_mapper_mem_sequencer;

  localparam int         AW = 27;
  localparam int         TO = 8;
  localparam logic [7:0] OB = 8'hFF;
`ifdef MAPPER_SEQ_LASTHIT_EN
  localparam bit LH = 1'b1;
`else
  localparam bit LH = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         terr;
    int         reqlen;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            delay;
    logic [7:0]    data;
  } plan_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mapper_mem_sequencer_if #(.ADDR_W(AW)) bus();

  mapper_mem_sequencer #(
    .ADDR_W(AW), .TIMEOUT(TO), .OPEN_BUS(OB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  // reference model state: last-read cache and sticky error
  bit            m_vld  = 1'b0;
  logic [AW-1:0] m_tag  = '0;
  logic [7:0]    m_byte = 8'd0;
  bit            m_terr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // one CPU read access (or an unmapped access when cs==0)
  task automatic access(input bit cs, input logic [AW-1:0] addr, input int d,
                        input logic [7:0] data, input bit fl, input bit ovl,
                        input bit drop, input int hold, input int idle);
    exp_t  e;
    plan_t p;
    bit    hit;
    int    n;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.ram_cs   = cs;
    bus.cpu_rd   = 1'b1;
    bus.ram_addr = addr;
    bus.flush    = 1'b0;
    if (!cs) begin
      #1 chk("unmapped_wait_start", bus.cpu_wait, 0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      #1 chk("unmapped_mem_req", bus.mem_req, 0);
      chk("unmapped_wait", bus.cpu_wait, 0);
      bus.cpu_rd = 1'b0;
      repeat (idle) @(negedge clk);
      return;
    end
    bus.flush = fl;
    hit = LH && m_vld && (m_tag == addr) && !fl;
    if (fl) m_vld = 1'b0;
    if (hit) begin
      e = '{m_byte, m_terr, 0};
    end else begin
      p = '{addr, d, data};
      plan_q.push_back(p);
      if (d <= TO - 1) begin
        e      = '{data, m_terr, d + 1};
        m_vld  = 1'b1;
        m_tag  = addr;
        m_byte = data;
      end else begin
        m_terr = 1'b1;
        e      = '{OB, 1'b1, TO};
      end
    end
    exp_q.push_back(e);
    #1 chk("wait_start", bus.cpu_wait, 1);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.flush   = 1'b0;
    if (ovl) begin
      bus.cpu_req  = 1'b1;
      bus.ram_addr = AW'($urandom);
    end
    n = 0;
    #1;
    while (bus.cpu_wait && n < TO + 20) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
      if (drop) bus.cpu_rd = 1'b0;
      n++;
      #1;
    end
    if (n >= TO + 20) begin
      checks++;
      failures++;
      $display("FAIL wait_bound actual=%0d required<%0d", n, TO + 20);
    end
    repeat (hold) @(negedge clk);
    bus.cpu_rd  = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    m_vld     = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  // memory controller model: answers each request after its planned delay
  initial begin
    plan_t p;
    int    w;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'd0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.mem_req) begin
        if (plan_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req actual=1 required=0");
        end else begin
          p = plan_q.pop_front();
          chk("mem_addr", bus.mem_addr, p.addr);
          for (int k = 0; k < p.delay; k++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) chk("mem_addr_stable", bus.mem_addr, p.addr);
          end
          bus.mem_ack  = 1'b1;
          bus.mem_data = p.data;
          @(negedge clk);
          #1;
          bus.mem_ack  = 1'b0;
          bus.mem_data = 8'($urandom);
        end
        w = 0;
        while (bus.mem_req && w < TO + 20) begin
          @(negedge clk);
          #1;
          w++;
        end
      end
    end
  end

  // monitor: a result is due in the cycle cpu_wait drops
  initial begin
    bit         pw;
    bit         have;
    logic [7:0] last;
    int         rc;
    exp_t       e;
    pw = 1'b0; have = 1'b0; rc = 0; last = 8'd0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pw = 1'b0; have = 1'b0; rc = 0;
        continue;
      end
      if (bus.mem_req) rc++;
      if (pw && !bus.cpu_wait) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h required=none", bus.cpu_data);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", bus.cpu_data, e.data);
          chk("result_valid", bus.data_valid, 1);
          chk("timeout_err", bus.timeout_err, e.terr);
          chk("req_cycles", rc, e.reqlen);
          last = e.data;
          have = 1'b1;
        end
        rc = 0;
      end else if (have && !bus.cpu_wait) begin
        chk("hold_data", bus.cpu_data, last);
        chk("hold_valid", bus.data_valid, 1);
      end
      pw = bus.cpu_wait;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, d;
    logic [AW-1:0] a;
    // reset values, with a would-be start held on the inputs
    reset        = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.ram_cs   = 1'b1;
    bus.cpu_rd   = 1'b1;
    bus.ram_addr = AW'(27'h0001234);
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wait", bus.cpu_wait, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_cpu_data", bus.cpu_data, OB);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    bus.cpu_req = 1'b0;
    bus.cpu_rd  = 1'b0;
    @(negedge clk);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);

    // basic read, unmapped access, ack in the expiry cycle
    access(1, AW'(27'h0004123), 2, 8'hA5, 0, 0, 0, 1, 4);
    access(0, AW'(27'h0000999), 0, 8'h00, 0, 0, 0, 0, 4);
    access(1, AW'(27'h0000040), TO - 1, 8'h6E, 0, 0, 0, 0, 4);
    access(1, AW'(27'h0000041), 0, 8'h12, 0, 0, 0, 0, 4);
    // timeout with late ack, then a normal read
    access(1, AW'(27'h0000200), TO + 1, 8'h11, 0, 0, 0, 2, 5);
    access(1, AW'(27'h0000300), 1, 8'h5A, 0, 0, 0, 0, 4);
    // overlapping cpu_req, cpu_rd dropped during REQ
    access(1, AW'(27'h0000777), 3, 8'hC3, 0, 1, 0, 0, 4);
    access(1, AW'(27'h0000778), 4, 8'h3D, 0, 0, 1, 0, 4);

    // reset two cycles into REQ, late ack afterwards
    @(negedge clk);
    plan_q.push_back('{AW'(27'h0000055), TO + 1, 8'h77});
    bus.cpu_req  = 1'b1;
    bus.ram_cs   = 1'b1;
    bus.cpu_rd   = 1'b1;
    bus.ram_addr = AW'(27'h0000055);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 chk("pre_reset_mem_req", bus.mem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_wait", bus.cpu_wait, 0);
    chk("mid_rst_cpu_data", bus.cpu_data, OB);
    chk("mid_rst_valid", bus.data_valid, 0);
    chk("mid_rst_timeout_err", bus.timeout_err, 0);
    bus.cpu_rd = 1'b0;
    m_vld  = 1'b0;
    m_terr = 1'b0;
    @(negedge clk);
    #3 reset = 1'b0;
    repeat (TO + 4) @(negedge clk);
    #1;
    chk("late_ack_mem_req", bus.mem_req, 0);
    chk("late_ack_valid", bus.data_valid, 0);
    chk("late_ack_cpu_data", bus.cpu_data, OB);

    // last-hit sequence (plain misses when the cache is not built)
    access(1, AW'(27'h0000010), 1, 8'h3C, 0, 0, 0, 0, 4);
    access(1, AW'(27'h0000010), 1, 8'h99, 0, 0, 0, 1, 4);
    do_flush();
    access(1, AW'(27'h0000010), 2, 8'h4B, 0, 0, 0, 0, 4);
    access(1, AW'(27'h0000010), 0, 8'h21, 1, 0, 0, 0, 4);
    access(1, AW'(27'h0000010), 0, 8'h22, 0, 0, 0, 0, 4);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      d = (r < 7) ? $urandom_range(0, 4) : $urandom_range(TO - 2, TO + 2);
      if ($urandom_range(0, 3) != 0) a = AW'($urandom_range(0, 3) * 256);
      else                           a = AW'($urandom);
      if ($urandom_range(0, 15) == 0) do_flush();
      access($urandom_range(0, 7) != 0, a, d, 8'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 2),
             $urandom_range(4, 6));
    end

    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("plan_q_drained", plan_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
